// File: rtl/pulse_trig_pkg.sv
// Shared types, default widths and the per-channel delay slice helper for pulse_trigger_gen.
package pulse_trig_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned DEF_CH_NUM   = 4;
    localparam int unsigned DEF_CYC_W    = 20;
    localparam int unsigned DEF_PW_W     = 12;
    localparam int unsigned DEF_DLY_W    = 10;
    localparam int unsigned DEF_BURST_W  = 8;
    localparam int unsigned DEF_CNT_W    = 16;
    localparam int unsigned DEF_DAMP_LEN = 50;

    // Widest packed delay vector the slice helper accepts.
    localparam int unsigned DLY_VEC_MAX = 256;

    function automatic logic [31:0] dly_slice(input logic [DLY_VEC_MAX-1:0] vec,
                                              input int unsigned            idx,
                                              input int unsigned            width);
        logic [DLY_VEC_MAX-1:0] sh;
        logic [31:0]            mask;
        sh   = vec >> (idx * width);
        mask = (32'd1 << width) - 32'd1;
        return sh[31:0] & mask;
    endfunction

endpackage

// File: rtl/pulse_chan.sv
// One trigger channel: window compare against the shared period counter, registered trig,
// and the post-pulse damping counter when DAMP_EN is defined.
module pulse_chan
    import pulse_trig_pkg::*;
#(
    parameter int unsigned CYC_W    = DEF_CYC_W,
    parameter int unsigned PW_W     = DEF_PW_W,
`ifdef DAMP_EN
    parameter int unsigned DAMP_LEN = DEF_DAMP_LEN,
`endif
    parameter int unsigned DLY_W    = DEF_DLY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
`ifdef DAMP_EN
    input  logic             clr,
`endif
    input  logic [CYC_W-1:0] pcnt,
    input  logic [DLY_W-1:0] dly,
    input  logic [PW_W-1:0]  pw,
    output logic             trig,
    output logic             damp
);

    logic [CYC_W:0] lo;
    logic [CYC_W:0] hi;
    logic           trig_d;
    logic           trig_q;

    // One extra bit so dly + pw never wraps; pcnt < cycle truncates the window at the wrap.
    always_comb begin
        lo     = (CYC_W+1)'(dly);
        hi     = lo + (CYC_W+1)'(pw);
        trig_d = run && ({1'b0, pcnt} >= lo) && ({1'b0, pcnt} < hi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig_d;
        end
    end

    assign trig = trig_q;

`ifdef DAMP_EN
    localparam int unsigned DW = $clog2(DAMP_LEN + 1);

    logic [DW-1:0] dcnt_d;
    logic [DW-1:0] dcnt_q;

    // A rising trig always wins over a running damp window so the two never overlap.
    always_comb begin
        dcnt_d = dcnt_q;
        if (clr || trig_d) begin
            dcnt_d = '0;
        end else if (trig_q) begin
            dcnt_d = DW'(DAMP_LEN);
        end else if (dcnt_q != '0) begin
            dcnt_d = dcnt_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
        end
    end

    assign damp = (dcnt_q != '0);
`else
    assign damp = 1'b0;
`endif

endmodule

// File: rtl/pulse_trigger_gen.sv
// Multi-channel phased ultrasonic trigger generator sharing one period counter.
// Optional damping outputs are built when the DAMP_EN macro is defined.
module pulse_trigger_gen
    import pulse_trig_pkg::*;
#(
    parameter int unsigned CH_NUM   = DEF_CH_NUM,
    parameter int unsigned CYC_W    = DEF_CYC_W,
    parameter int unsigned PW_W     = DEF_PW_W,
    parameter int unsigned DLY_W    = DEF_DLY_W,
    parameter int unsigned BURST_W  = DEF_BURST_W,
`ifdef DAMP_EN
    parameter int unsigned DAMP_LEN = DEF_DAMP_LEN,
`endif
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    start,
    input  logic [CYC_W-1:0]        cycle,
    input  logic [PW_W-1:0]         pulse,
    input  logic [CH_NUM*DLY_W-1:0] delay,
    input  logic [BURST_W-1:0]      burst,
    output logic [CH_NUM-1:0]       trig,
    output logic [CH_NUM-1:0]       damp,
    output logic                    sync,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        fire_cnt
);

    state_e                  state_d, state_q;
    logic [CYC_W-1:0]        pcnt_d, pcnt_q;
    logic [CNT_W-1:0]        fire_d, fire_q;
    logic [CYC_W-1:0]        cyc_s;
    logic [PW_W-1:0]         pw_s;
    logic [CH_NUM*DLY_W-1:0] dly_s;
    logic [BURST_W-1:0]      burst_s;
    logic                    sync_q, busy_q, done_q;
    logic                    fin_d, fin_q;
    logic                    launch, wrap, last, load_cfg, run;
    logic [CNT_W-1:0]        fire_inc;

    assign run = (state_q == RUN);

    always_comb begin
        launch   = (state_q == IDLE) && start && en && (cycle >= CYC_W'(2));
        // Compare at CYC_W+1 bits so a degenerate reloaded cycle still wraps every clock.
        wrap     = ({1'b0, pcnt_q} + (CYC_W+1)'(1)) >= {1'b0, cyc_s};
        fire_inc = fire_q + CNT_W'(1);
        last     = (burst_s != '0) && (fire_inc == CNT_W'(burst_s));
    end

    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        fire_d   = fire_q;
        load_cfg = 1'b0;
        fin_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d  = RUN;
                    pcnt_d   = '0;
                    fire_d   = '0;
                    load_cfg = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    pcnt_d   = '0;
                    fire_d   = fire_inc;
                    load_cfg = 1'b1;
                    if (last) begin
                        state_d = IDLE;
                        fin_d   = 1'b1;
                    end
                end else begin
                    pcnt_d = pcnt_q + CYC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            fire_q  <= '0;
            cyc_s   <= '0;
            pw_s    <= '0;
            dly_s   <= '0;
            burst_s <= '0;
            sync_q  <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            fire_q  <= fire_d;
            if (load_cfg) begin
                cyc_s <= cycle;
                pw_s  <= pulse;
                dly_s <= delay;
            end
            // The burst length is fixed for the whole run once launched.
            if (launch) begin
                burst_s <= burst;
            end
            sync_q <= run && (pcnt_q == '0);
            busy_q <= run;
            fin_q  <= fin_d;
            done_q <= fin_q;
        end
    end

`ifdef DAMP_EN
    logic abort_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= !en;
        end
    end
`endif

    for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
        logic [DLY_W-1:0] dly_g;

        assign dly_g = DLY_W'(dly_slice(DLY_VEC_MAX'(dly_s), g, DLY_W));

        pulse_chan #(
            .CYC_W    (CYC_W),
            .PW_W     (PW_W),
`ifdef DAMP_EN
            .DAMP_LEN (DAMP_LEN),
`endif
            .DLY_W    (DLY_W)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .run   (run),
`ifdef DAMP_EN
            .clr   (abort_q),
`endif
            .pcnt  (pcnt_q),
            .dly   (dly_g),
            .pw    (pw_s),
            .trig  (trig[g]),
            .damp  (damp[g])
        );
    end

    assign sync     = sync_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fire_cnt = fire_q;

endmodule

// File: doc/pulse_trigger_gen.md
Name: pulse_trigger_gen

Overview:
Multi-channel ultrasonic transmit trigger generator. It is the parametrised successor of the single-channel fixed-rate pulser. It produces CH_NUM phased trigger pulses that share one period counter, with a programmable per-channel firing delay and a burst or continuous mode. It sits between the control register file and the pulser drive pins, and its sync strobe feeds the acquisition/DAC path.

Parameters:
CH_NUM, 4, number of trigger channels
CYC_W, 20, width of period counter and cycle input (unit 10 ns at 100 MHz)
PW_W, 12, width of pulse-width input
DLY_W, 10, width of each per-channel delay
BURST_W, 8, width of burst-count input
CNT_W, 16, width of fired-period counter
DAMP_LEN, 50, damping window length in clocks (only with DAMP_EN)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous, active-low reset
en  in  1  level enable; low aborts and holds the block idle
start  in  1  one-clock launch pulse
cycle  in  CYC_W  period length in clocks
pulse  in  PW_W  high time of every channel pulse in clocks
delay  in  CH_NUM*DLY_W  per-channel delay from period start; channel i uses bits [i*DLY_W +: DLY_W]
burst  in  BURST_W  number of periods to fire; 0 means continuous
trig  out  CH_NUM  trigger outputs, active high
damp  out  CH_NUM  damping drive, active high
sync  out  1  one-clock strobe at each period start
busy  out  1  high while in RUN
done  out  1  one-clock strobe when a burst completes normally
fire_cnt  out  CNT_W  completed periods since last start; wraps

Behaviour:
- Reset (asynchronous): state IDLE, pcnt 0, shadow registers 0, trig/damp/sync/busy/done 0, fire_cnt 0.
- FSM has 2 states, IDLE and RUN.
- IDLE -> RUN on start=1, en=1 and cycle>=2. On that edge: pcnt<=0; shadow cyc/pw/dly/burst loaded; fire_cnt<=0.
- start is ignored when en=0, when cycle<2, or when already in RUN.
- RUN: pcnt increments each clock; at pcnt==cyc_s-1 it wraps to 0, fire_cnt increments, and shadows reload from the inputs. Config changes therefore take effect only at the period boundary.
- Burst mode (burst_s!=0): after the burst_s-th period completes (wrap edge), the FSM goes to IDLE and done pulses for one clock, coincident with busy falling.
- Continuous mode (burst_s==0): the block runs until en falls.
- en=0 in RUN: the FSM goes to IDLE at that edge; trig/damp/sync go 0 the next cycle; no done; fire_cnt holds.
- Channel i window: active while dly_i <= pcnt < dly_i + pw_s. The sum is computed at CYC_W+1 bits with no wrap. A window that extends past the period end is truncated at the wrap, and no part of it fires in the next period.
- pw_s==0 gives no pulse. dly_i >= cyc_s gives no pulse for that channel.
- trig, sync and done are registered: one clock latency from pcnt. sync is registered (pcnt==0 && RUN).
- busy equals (state==RUN), registered.

Optional Feature:
DAMP_EN
- Defined: on each falling edge of trig[i], damp[i] is high for exactly DAMP_LEN clocks, via a per-channel down-counter.
- A new trig[i] rise cuts damp[i] low in that same cycle; damp and trig are never both high.
- Abort or reset clears damp.
- Undefined: damp is tied to 0 and the counters are not built.

Decomposition:
- Package pulse_trig_pkg holds:
  - state enum {IDLE, RUN};
  - default width localparams;
  - the CH_NUM*DLY_W slice helper function.
- Sub-module pulse_chan holds the per-channel window compare, trig register, and damping counter under DAMP_EN. It is instantiated CH_NUM times with generate.
- The top level holds the FSM, period counter, shadows, sync/done/busy and fire_cnt.

Test Plan:
- cycle=10, pulse=3, delays {0,2,4,9}, burst=2, start -> trig0 high clocks 1-3 and 11-13 after start; trig1 offset +2; trig3 high 1 clock then truncated; sync at 1 and 11; done at 21; fire_cnt=2.
- burst=0, cycle=5, pulse=1 -> continuous 5-clock trig0; drop en mid-period -> all outputs 0 next cycle, no done, busy 0.
- Change pulse 3->5 mid-period -> current period keeps width 3, next period uses width 5.
- cycle=1, start -> stays IDLE, busy 0. pulse=0 -> RUN with sync only, no trig.
- Reset asserted mid-pulse -> trig, sync, busy and fire_cnt all 0 immediately (asynchronous).
- DAMP_EN, DAMP_LEN=50, cycle=40, pulse=4 -> damp0 high for clocks 5-40 after each trig fall, cut at the next trig rise. Without the macro, damp stays 0.
